// File: rtl/fpu_addsub_iter.sv
// Multi-cycle IEEE-754 add/subtract unit, parametrised in exponent and
// fraction width. One operation in flight; start/ready accept, done pulse.
// Pipeline of states: ALIGN -> ADD -> NORM -> ROUND -> DONE.
module fpu_addsub_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         start,
    output logic                         ready,
    input  logic                         op,
    input  logic [2:0]                   frm,
    input  logic [1+EXP_W+MAN_W-1:0]     floating_point1,
    input  logic [1+EXP_W+MAN_W-1:0]     floating_point2,
    output logic [1+EXP_W+MAN_W-1:0]     floating_point_out,
    output logic [4:0]                   flags,
    output logic                         done
);

    localparam int W  = 1 + EXP_W + MAN_W;
    // significand incl. hidden bit plus guard/round/sticky
    localparam int SW = MAN_W + 4;
    // exponent arithmetic width with headroom for carry and rounding carry
    localparam int EW = EXP_W + 2;

    localparam logic [EW-1:0]  E_ONE    = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0]  E_ZERO   = {EW{1'b0}};
    localparam logic [EW-1:0]  E_MAX    = {2'b00, {EXP_W{1'b1}}};
    localparam logic [EW-1:0]  E_SW     = EW'(SW);
    localparam logic [W-1:0]   QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic [W-2:0]   INF_MAG  = {{EXP_W{1'b1}}, {MAN_W{1'b0}}};
    localparam logic [W-2:0]   MAXF_MAG = {{(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RTZ = 3'b001;
    localparam logic [2:0] RM_RDN = 3'b010;
    localparam logic [2:0] RM_RUP = 3'b011;
    localparam logic [2:0] RM_RMM = 3'b100;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        ADD   = 3'd2,
        NORM  = 3'd3,
        ROUND = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state_r, state_next_s;
    logic   accept_s;

    // latched request
    logic [W-1:0] a_r, b_r;
    logic         op_r;
    logic [2:0]   rm_r;

    // ALIGN results
    logic          sign_big_r, sign_small_r;
    logic [EW-1:0] exp_big_r;
    logic [SW-1:0] sig_big_r, sig_small_r;
    logic          special_r;
    logic [W-1:0]  special_res_r;
    logic [4:0]    special_flags_r;

    // ADD / NORM results
    logic [SW:0]   sum_r;
    logic [SW-1:0] norm_sig_r;
    logic [EW-1:0] norm_exp_r;

    // leading-zero count of the un-normalised significand
    function automatic logic [EW-1:0] lzc(input logic [SW-1:0] v);
        logic [EW-1:0] n;
        logic          hit;
        n   = {EW{1'b0}};
        hit = 1'b0;
        for (int i = SW - 1; i >= 0; i--) begin
            if (!hit && v[i]) begin
                hit = 1'b1;
            end else if (!hit) begin
                n = n + E_ONE;
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // next-state logic; a new request is taken whenever ready is high
    always_comb begin
        state_next_s = state_r;
        accept_s     = start & ready;
        case (state_r)
            IDLE:    state_next_s = start ? ALIGN : IDLE;
            ALIGN:   state_next_s = ADD;
            ADD:     state_next_s = NORM;
            NORM:    state_next_s = ROUND;
            ROUND:   state_next_s = DONE;
            DONE:    state_next_s = start ? ALIGN : IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // state register with registered ready/done derived from the next state
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_r <= IDLE;
            ready   <= 1'b1;
            done    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            ready   <= (state_next_s == IDLE) || (state_next_s == DONE);
            done    <= (state_next_s == DONE);
        end
    end

    // capture operands and controls on accept
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            a_r  <= {W{1'b0}};
            b_r  <= {W{1'b0}};
            op_r <= 1'b0;
            rm_r <= 3'b000;
        end else if (accept_s) begin
            a_r  <= floating_point1;
            b_r  <= floating_point2;
            op_r <= op;
            rm_r <= frm;
        end
    end

    // ---------------- ALIGN: unpack, swap, shift, specials ----------------
    logic          sa_s, sb_s, swap_s;
    logic          sign_big_s, sign_small_s;
    logic [W-2:0]  mag_big_s, mag_small_s;
    logic [EW-1:0] eb_eff_s, es_eff_s, diff_s;
    logic [SW-1:0] sig_big_s, sig_small_raw_s, sig_small_s;
    logic [2*SW-1:0] ext_s;
    logic          a_nan_s, b_nan_s, a_snan_s, b_snan_s, a_inf_s, b_inf_s;
    logic          special_s;
    logic [W-1:0]  special_res_s;
    logic [4:0]    special_flags_s;

    // magnitude ordering, alignment shift with sticky collapse, special operands
    always_comb begin
        sa_s   = a_r[W-1];
        sb_s   = b_r[W-1] ^ op_r;
        swap_s = (b_r[W-2:0] > a_r[W-2:0]);
        if (swap_s) begin
            mag_big_s    = b_r[W-2:0];
            sign_big_s   = sb_s;
            mag_small_s  = a_r[W-2:0];
            sign_small_s = sa_s;
        end else begin
            mag_big_s    = a_r[W-2:0];
            sign_big_s   = sa_s;
            mag_small_s  = b_r[W-2:0];
            sign_small_s = sb_s;
        end
        // subnormals use exponent 1 with hidden bit 0
        if (mag_big_s[W-2:MAN_W] == {EXP_W{1'b0}}) begin
            eb_eff_s = E_ONE;
        end else begin
            eb_eff_s = {2'b00, mag_big_s[W-2:MAN_W]};
        end
        if (mag_small_s[W-2:MAN_W] == {EXP_W{1'b0}}) begin
            es_eff_s = E_ONE;
        end else begin
            es_eff_s = {2'b00, mag_small_s[W-2:MAN_W]};
        end
        sig_big_s       = {(mag_big_s[W-2:MAN_W] != {EXP_W{1'b0}}), mag_big_s[MAN_W-1:0], 3'b000};
        sig_small_raw_s = {(mag_small_s[W-2:MAN_W] != {EXP_W{1'b0}}), mag_small_s[MAN_W-1:0], 3'b000};
        diff_s          = eb_eff_s - es_eff_s;
        ext_s           = {sig_small_raw_s, {SW{1'b0}}} >> diff_s;
        if (diff_s >= E_SW) begin
            sig_small_s = {{(SW-1){1'b0}}, |sig_small_raw_s};
        end else begin
            sig_small_s = ext_s[2*SW-1:SW] | {{(SW-1){1'b0}}, |ext_s[SW-1:0]};
        end

        a_nan_s  = (&a_r[W-2:MAN_W]) & (|a_r[MAN_W-1:0]);
        b_nan_s  = (&b_r[W-2:MAN_W]) & (|b_r[MAN_W-1:0]);
        a_snan_s = a_nan_s & ~a_r[MAN_W-1];
        b_snan_s = b_nan_s & ~b_r[MAN_W-1];
        a_inf_s  = (&a_r[W-2:MAN_W]) & ~(|a_r[MAN_W-1:0]);
        b_inf_s  = (&b_r[W-2:MAN_W]) & ~(|b_r[MAN_W-1:0]);

        special_s       = 1'b1;
        special_res_s   = QNAN;
        special_flags_s = 5'b00000;
        if (a_nan_s || b_nan_s) begin
            special_flags_s = {(a_snan_s | b_snan_s), 4'b0000};
        end else if (a_inf_s && b_inf_s && (sa_s != sb_s)) begin
            special_flags_s = 5'b10000;
        end else if (a_inf_s) begin
            special_res_s = {sa_s, INF_MAG};
        end else if (b_inf_s) begin
            special_res_s = {sb_s, INF_MAG};
        end else begin
            special_s = 1'b0;
        end
    end

    // register the aligned operands
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sign_big_r      <= 1'b0;
            sign_small_r    <= 1'b0;
            exp_big_r       <= E_ZERO;
            sig_big_r       <= {SW{1'b0}};
            sig_small_r     <= {SW{1'b0}};
            special_r       <= 1'b0;
            special_res_r   <= {W{1'b0}};
            special_flags_r <= 5'b00000;
        end else if (state_r == ALIGN) begin
            sign_big_r      <= sign_big_s;
            sign_small_r    <= sign_small_s;
            exp_big_r       <= eb_eff_s;
            sig_big_r       <= sig_big_s;
            sig_small_r     <= sig_small_s;
            special_r       <= special_s;
            special_res_r   <= special_res_s;
            special_flags_r <= special_flags_s;
        end
    end

    // ---------------- ADD ----------------
    logic sub_s;

    // effective subtraction when the aligned signs differ
    always_comb begin
        sub_s = sign_big_r ^ sign_small_r;
    end

    // significand add/subtract; big >= small so the difference is never negative
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sum_r <= {(SW+1){1'b0}};
        end else if (state_r == ADD) begin
            if (sub_s) begin
                sum_r <= {1'b0, sig_big_r} - {1'b0, sig_small_r};
            end else begin
                sum_r <= {1'b0, sig_big_r} + {1'b0, sig_small_r};
            end
        end
    end

    // ---------------- NORM ----------------
    logic [EW-1:0] lz_s, lim_s, sh_s, norm_exp_s;
    logic [SW-1:0] norm_sig_s;

    // carry -> shift right; otherwise left-shift, stopping at exponent 1
    always_comb begin
        lz_s  = lzc(sum_r[SW-1:0]);
        lim_s = exp_big_r - E_ONE;
        sh_s  = (lz_s < lim_s) ? lz_s : lim_s;
        if (sum_r[SW]) begin
            norm_sig_s = {sum_r[SW:2], sum_r[1] | sum_r[0]};
            norm_exp_s = exp_big_r + E_ONE;
        end else begin
            norm_sig_s = sum_r[SW-1:0] << sh_s;
            norm_exp_s = exp_big_r - sh_s;
        end
    end

    // register the normalised significand
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            norm_sig_r <= {SW{1'b0}};
            norm_exp_r <= E_ZERO;
        end else if (state_r == NORM) begin
            norm_sig_r <= norm_sig_s;
            norm_exp_r <= norm_exp_s;
        end
    end

    // ---------------- ROUND ----------------
    logic             g_s, r_s, st_s, lsb_s, inexact_s, up_s, sign_s, zero_s, of_s, uf_s;
    logic [MAN_W+1:0] m2_s;
    logic [EW-1:0]    exp_f_s;
    logic [MAN_W-1:0] frac_s;
    logic [W-1:0]     res_s;
    logic [4:0]       flags_s;

    // rounding, zero sign, overflow/underflow and flag assembly
    always_comb begin
        lsb_s     = norm_sig_r[3];
        g_s       = norm_sig_r[2];
        r_s       = norm_sig_r[1];
        st_s      = norm_sig_r[0];
        inexact_s = g_s | r_s | st_s;
        zero_s    = (norm_sig_r == {SW{1'b0}});
        if (zero_s && sub_s) begin
            sign_s = (rm_r == RM_RDN);
        end else begin
            sign_s = sign_big_r;
        end
        case (rm_r)
            RM_RNE:  up_s = g_s & (r_s | st_s | lsb_s);
            RM_RTZ:  up_s = 1'b0;
            RM_RDN:  up_s = inexact_s & sign_s;
            RM_RUP:  up_s = inexact_s & ~sign_s;
            RM_RMM:  up_s = g_s;
            default: up_s = g_s & (r_s | st_s | lsb_s);
        endcase
        m2_s = {1'b0, norm_sig_r[SW-1:3]} + {{(MAN_W+1){1'b0}}, up_s};
        if (m2_s[MAN_W+1]) begin
            exp_f_s = norm_exp_r + E_ONE;
            frac_s  = m2_s[MAN_W:1];
        end else begin
            exp_f_s = m2_s[MAN_W] ? norm_exp_r : E_ZERO;
            frac_s  = m2_s[MAN_W-1:0];
        end
        of_s = (exp_f_s >= E_MAX);
        uf_s = (exp_f_s == E_ZERO) & inexact_s;
        res_s = {sign_s, exp_f_s[EXP_W-1:0], frac_s};
        if (of_s) begin
            case (rm_r)
                RM_RTZ:  res_s = {sign_s, MAXF_MAG};
                RM_RDN:  res_s = {sign_s, (sign_s ? INF_MAG : MAXF_MAG)};
                RM_RUP:  res_s = {sign_s, (sign_s ? MAXF_MAG : INF_MAG)};
                default: res_s = {sign_s, INF_MAG};
            endcase
        end else begin
            res_s = {sign_s, exp_f_s[EXP_W-1:0], frac_s};
        end
        flags_s = {1'b0, 1'b0, of_s, uf_s, inexact_s | of_s};
        if (special_r) begin
            res_s   = special_res_r;
            flags_s = special_flags_r;
        end else begin
            flags_s = {1'b0, 1'b0, of_s, uf_s, inexact_s | of_s};
        end
    end

    // result and flags registers, updated only at the end of ROUND
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            floating_point_out <= {W{1'b0}};
            flags              <= 5'b00000;
        end else if (state_r == ROUND) begin
            floating_point_out <= res_s;
            flags              <= flags_s;
        end
    end

endmodule

// File: tb/tb_fpu_addsub_iter.sv
// Directed bench for fpu_addsub_iter: single precision vectors plus one
// half-precision instance, with latency, pulse-width and reset-abort checks.
module tb_fpu_addsub_iter;

    logic        clk = 1'b0;
    logic        nrst;
    logic        start, ready, op, done;
    logic [2:0]  frm;
    logic [31:0] fp1, fp2, out;
    logic [4:0]  flg;

    logic        h_start, h_ready, h_op, h_done;
    logic [2:0]  h_frm;
    logic [15:0] h1, h2, hout;
    logic [4:0]  hflg;

    int total = 0;
    int bad   = 0;

    fpu_addsub_iter dut (
        .clk(clk), .nrst(nrst), .start(start), .ready(ready), .op(op), .frm(frm),
        .floating_point1(fp1), .floating_point2(fp2),
        .floating_point_out(out), .flags(flg), .done(done)
    );

    fpu_addsub_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .nrst(nrst), .start(h_start), .ready(h_ready), .op(h_op), .frm(h_frm),
        .floating_point1(h1), .floating_point2(h2),
        .floating_point_out(hout), .flags(hflg), .done(h_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // one operation on the single-precision unit; checks result, flags, latency, pulse width
    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [2:0] rm,
                       input logic [31:0] want, input logic [4:0] wflags);
        int lat;
        @(negedge clk);
        fp1 = a; fp2 = b; op = o; frm = rm; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_res"}, out, want);
        chk({tag, "_flags"}, {27'd0, flg}, {27'd0, wflags});
        chk({tag, "_lat"}, lat, 32'd5);
        @(negedge clk);
        chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        nrst = 1'b0; start = 1'b0; op = 1'b0; frm = 3'b000; fp1 = 32'd0; fp2 = 32'd0;
        h_start = 1'b0; h_op = 1'b0; h_frm = 3'b000; h1 = 16'd0; h2 = 16'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done",  {31'd0, done},  32'd0);
        chk("rst_out",   out, 32'd0);
        chk("rst_flags", {27'd0, flg}, 32'd0);
        nrst = 1'b1;

        run("add_1_2",    32'h3F800000, 32'h40000000, 1'b0, 3'b000, 32'h40400000, 5'b00000);
        run("sub_eq_rne", 32'h3F800000, 32'h3F800000, 1'b1, 3'b000, 32'h00000000, 5'b00000);
        run("sub_eq_rdn", 32'h3F800000, 32'h3F800000, 1'b1, 3'b010, 32'h80000000, 5'b00000);
        run("ovf_rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b000, 32'h7F800000, 5'b00101);
        run("ovf_rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'b001, 32'h7F7FFFFF, 5'b00101);
        run("ovf_neg_rdn",32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b010, 32'hFF800000, 5'b00101);
        run("ovf_neg_rup",32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'b011, 32'hFF7FFFFF, 5'b00101);
        run("half_rne",   32'h3F800000, 32'h33800000, 1'b0, 3'b000, 32'h3F800000, 5'b00001);
        run("half_rup",   32'h3F800000, 32'h33800000, 1'b0, 3'b011, 32'h3F800001, 5'b00001);
        run("half_rmm",   32'h3F800000, 32'h33800000, 1'b0, 3'b100, 32'h3F800001, 5'b00001);
        run("qtr_rne",    32'h3F800000, 32'h33000000, 1'b0, 3'b000, 32'h3F800000, 5'b00001);
        run("qtr_rup",    32'h3F800000, 32'h33000000, 1'b0, 3'b011, 32'h3F800001, 5'b00001);
        run("sub_renorm", 32'h40000000, 32'h3F800000, 1'b1, 3'b000, 32'h3F800000, 5'b00000);
        run("sub_ulp",    32'h3F800000, 32'h33800000, 1'b1, 3'b000, 32'h3F7FFFFF, 5'b00000);
        run("inf_m_inf",  32'h7F800000, 32'hFF800000, 1'b0, 3'b000, 32'h7FC00000, 5'b10000);
        run("snan",       32'h7F800001, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'b10000);
        run("qnan",       32'h7FC00001, 32'h3F800000, 1'b0, 3'b000, 32'h7FC00000, 5'b00000);
        run("inf_p_fin",  32'h7F800000, 32'h3F800000, 1'b0, 3'b000, 32'h7F800000, 5'b00000);
        run("fin_m_inf",  32'h3F800000, 32'h7F800000, 1'b1, 3'b000, 32'hFF800000, 5'b00000);
        run("subnorm",    32'h00000001, 32'h00000001, 1'b0, 3'b000, 32'h00000002, 5'b00000);
        run("negz",       32'h80000000, 32'h80000000, 1'b0, 3'b000, 32'h80000000, 5'b00000);

        // back-to-back with start held high
        @(negedge clk);
        fp1 = 32'h3F800000; fp2 = 32'h40000000; op = 1'b0; frm = 3'b000; start = 1'b1;
        @(posedge clk);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_lat1", n, 32'd5);
        chk("b2b_res1", out, 32'h40400000);
        fp1 = 32'h3F800000; fp2 = 32'h3F800000;
        n = 0;
        @(negedge clk);
        n++;
        start = 1'b0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_gap", n, 32'd5);
        chk("b2b_res2", out, 32'h40000000);

        // reset while the operation sits in NORM
        @(negedge clk);
        fp1 = 32'h3F800000; fp2 = 32'h40000000; op = 1'b0; frm = 3'b000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("abort_out",   out, 32'd0);
        chk("abort_flags", {27'd0, flg}, 32'd0);
        chk("abort_ready", {31'd0, ready}, 32'd1);
        chk("abort_done",  {31'd0, done}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_nodone", seen, 32'd0);

        // half-precision instance
        @(negedge clk);
        h1 = 16'h3C00; h2 = 16'h3C00; h_op = 1'b0; h_frm = 3'b000; h_start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        h_start = 1'b0;
        n = 1;
        while (!h_done && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("half_res",   {16'd0, hout}, 32'h00004000);
        chk("half_flags", {27'd0, hflg}, 32'd0);
        chk("half_lat",   n, 32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_addsub_iter.md
Name: fpu_addsub_iter

Overview:
- Parametrised, multi-cycle IEEE-754 floating-point add/subtract unit with a start/done handshake.
- Successor to the fixed single-precision adder path in FPU_top_level.
- Generalised in format width through EXP_W/MAN_W.
- Supports all five RISC-V rounding modes, full subnormal, infinity and NaN handling, and RISC-V fflags.
- Instantiated by the FPU top level for FADD/FSUB; one operation is in flight at a time.

Parameters:
EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 23, stored fraction width; total word W = 1+EXP_W+MAN_W

Ports:
clk  input  1  clock, rising edge
nrst  input  1  asynchronous active-low reset
start  input  1  request; accepted when start && ready at a rising edge
ready  output  1  unit can accept start (high in IDLE and DONE)
op  input  1  0 = fp1+fp2, 1 = fp1-fp2; sampled on accept
frm  input  3  rounding mode, sampled on accept: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101/110/111 behave as RNE
floating_point1  input  W  operand A, sampled on accept
floating_point2  input  W  operand B, sampled on accept
floating_point_out  output  W  result; registered, valid when done
flags  output  5  {NV,DZ,OF,UF,NX}; registered, valid when done; DZ always 0
done  output  1  one-cycle pulse, result valid

Behaviour:
- Reset (nrst low, asynchronous): state=IDLE, ready=1, done=0, floating_point_out=0, flags=0, all internal registers cleared. Reset mid-operation aborts the operation; no done is produced.
- FSM states and transitions:
  - IDLE -(accept)-> ALIGN. On accept: operands, op and frm latched; effective B sign = B sign XOR op.
  - ALIGN: unpack (hidden bit 1 if exp != 0, else 0 with exp treated as 1); swap so |A| >= |B|; right-shift the smaller significand by the exponent difference into guard/round/sticky. Sticky = OR of all bits shifted past round; a shift >= MAN_W+4 leaves sticky-only. -> ADD.
  - ADD: add or subtract significands (MAN_W+5 bits including carry). -> NORM.
  - NORM: on carry-out, shift right 1 (sticky accumulates) and exp+1. Otherwise left-shift by leading-zero count (combinational LZC), limited so exp does not drop below 1 (subnormal result). -> ROUND.
  - ROUND: apply frm using guard/round/sticky and sign. Rounding carry renormalises (exp+1). Register out/flags. -> DONE.
  - DONE: done=1 for exactly this cycle; ready=1. -> ALIGN if start, else IDLE.
- Latency: done is high in the cycle following the 4th rising edge after the accepting edge. Back-to-back throughput is one op per 5 cycles.
- Outputs hold their last value until overwritten by the next ROUND; inputs are ignored outside accept.
- Special cases (resolved in ALIGN, still reported at the normal latency):
  - Any sNaN input -> NV.
  - Any NaN input -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0).
  - Inf + (-Inf) effective -> canonical qNaN, NV.
  - Inf op finite -> Inf with the sign of the Inf operand.
- Zero results:
  - Exact zero from unlike signs -> +0, except RDN -> -0.
  - (+0)+(+0) = +0; (-0)+(-0) = -0.
- Overflow (rounded exp >= all-ones): OF|NX.
  - RNE/RMM -> Inf.
  - RTZ -> max finite.
  - RDN -> max finite if positive, -Inf if negative.
  - RUP -> +Inf if positive, max finite if negative.
- Underflow: UF only when the result is tiny (after rounding, exp field 0) AND inexact. Subnormal outputs are not flushed.
- NX whenever any of guard/round/sticky is nonzero after normalisation.

Test Plan:
- Reset, then start with A=3F800000, B=40000000, op=0, frm=000 -> out=40400000, flags=00000; done high exactly 1 cycle, on the 5th cycle after accept.
- A=3F800000, B=3F800000, op=1: frm=000 -> 00000000; frm=010 -> 80000000; flags=00000.
- A=7F7FFFFF, B=7F7FFFFF, op=0: frm=000 -> 7F800000, flags=00101; frm=001 -> 7F7FFFFF, flags=00101.
- A=3F800000, B=33800000, op=0 (halfway): frm=000 -> 3F800000, flags=00001; frm=011 -> 3F800001; frm=100 -> 3F800001.
- Specials: 7F800000 + FF800000 -> 7FC00000, flags=10000. 7F800001 + 3F800000 -> 7FC00000, flags=10000. 00000001 + 00000001 -> 00000002, flags=00000.
- Control and format: start held high -> second accept taken in the DONE cycle, ops 5 cycles apart. nrst pulsed low during NORM -> outputs 0, no done pulse, ready=1. Instance with EXP_W=5, MAN_W=10: 3C00 + 3C00 -> 4000, flags=00000.
